// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds geometry parameters, the controller state encoding and the
// line-address helper used when talking to main memory.
package dcache_pkg;
    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 256;
    localparam int NUM_LINES = 32;
    localparam int OFFSET_W  = 5;
    localparam int INDEX_W   = 5;
    localparam int TAG_W     = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WORDS     = LINE_W / WORD_W;
    localparam int WSEL_W    = 3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_SETTLE    = 2'd3
    } state_e;

    // Line-aligned byte address built from a tag and an index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction
endpackage

// File: rtl/dcache_if.sv
// Line-wide memory bus between the cache (master) and main memory (slave).
//   mem_addr_o   line-aligned address
//   mem_data_o   write-back line
//   mem_enable_o request, held until mem_ack_i
//   mem_write_o  1 = write-back, 0 = refill
//   mem_data_i   refill line, valid with mem_ack_i
//   mem_ack_i    single-cycle completion pulse
interface dcache_if;
    import dcache_pkg::*;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport master (output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
                    input  mem_data_i, mem_ack_i);
    modport slave  (input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
                    output mem_data_i, mem_ack_i);
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the cache. Async read of one set,
// sync write with a per-word enable so both full-line refills and
// single-word stores use the same port.
//   idx_i                      set index (read and write)
//   tag_o/valid_o/dirty_o/line_o  contents of the indexed set
//   we_i, wen_i, wdata_i       write strobe, word enables, line data
//   wtag_i, wdirty_i           tag and dirty value written with we_i
module dcache_sram
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] idx_i,
    output logic [TAG_W-1:0]   tag_o,
    output logic               valid_o,
    output logic               dirty_o,
    output logic [LINE_W-1:0]  line_o,
    input  logic               we_i,
    input  logic [WORDS-1:0]   wen_i,
    input  logic [LINE_W-1:0]  wdata_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic               wdirty_i
);
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];
    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= wdirty_i;
        end
    end

    // Tag and data arrays are never cleared; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[idx_i] <= wtag_i;
            for (int w = 0; w < WORDS; w++) begin
                if (wen_i[w]) data_q[idx_i][w*WORD_W +: WORD_W] <= wdata_i[w*WORD_W +: WORD_W];
            end
        end
    end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are served combinationally; a miss stalls the pipeline while the
// victim line is written back (if dirty) and the new line is refilled.
//   clk_i, rst_i          clock, synchronous active-high reset
//   p1_*                  CPU request/response (addr, store data, MemRead,
//                         MemWrite, load data, stall)
//   mem                   line-wide memory bus (master side)
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    dcache_if.master          mem
);
    state_e            state_q;
    logic              en_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wb_data_q;

    logic [TAG_W-1:0]   req_tag, rd_tag;
    logic [INDEX_W-1:0] idx;
    logic [WSEL_W-1:0]  wsel;
    logic               rd_valid, rd_dirty;
    logic [LINE_W-1:0]  rd_line;
    logic               req, hit, cpu_wr, refill;
    logic [1:0]         unused_addr_bits;

    assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign idx              = p1_addr_i[OFFSET_W +: INDEX_W];
    assign wsel             = p1_addr_i[OFFSET_W-1:2];
    assign unused_addr_bits = p1_addr_i[1:0];

    assign req        = p1_MemRead_i | p1_MemWrite_i;
    assign hit        = req & rd_valid & (rd_tag == req_tag);
    assign p1_stall_o = req & ~hit & ~rst_i;
    assign p1_data_o  = (~rst_i & hit & p1_MemRead_i & ~p1_MemWrite_i)
                        ? rd_line[wsel*WORD_W +: WORD_W] : '0;

    // Stores only land outside a transfer, so a request that changes
    // mid-stall cannot touch a set while its line is in flight.
    assign cpu_wr = ~rst_i & hit & p1_MemWrite_i &
                    ((state_q == S_IDLE) | (state_q == S_SETTLE));
    assign refill = ~rst_i & (state_q == S_REFILL) & mem.mem_ack_i;

    dcache_sram u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .idx_i    (idx),
        .tag_o    (rd_tag),
        .valid_o  (rd_valid),
        .dirty_o  (rd_dirty),
        .line_o   (rd_line),
        .we_i     (cpu_wr | refill),
        .wen_i    (refill ? {WORDS{1'b1}} : (WORDS'(1) << wsel)),
        .wdata_i  (refill ? mem.mem_data_i : {WORDS{p1_data_i}}),
        .wtag_i   (req_tag),
        .wdirty_i (~refill)
    );

    assign mem.mem_enable_o = en_q;
    assign mem.mem_write_o  = wr_q;
    assign mem.mem_addr_o   = addr_q;
    assign mem.mem_data_o   = wb_data_q;

    // Bus outputs are registered and set up on entry to each state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wb_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req && !hit) begin
                    en_q <= 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_q   <= S_WRITEBACK;
                        wr_q      <= 1'b1;
                        addr_q    <= line_addr(rd_tag, idx);
                        wb_data_q <= rd_line;
                    end else begin
                        state_q <= S_REFILL;
                        wr_q    <= 1'b0;
                        addr_q  <= line_addr(req_tag, idx);
                    end
                end
                S_WRITEBACK: if (mem.mem_ack_i) begin
                    state_q <= S_REFILL;
                    wr_q    <= 1'b0;
                    addr_q  <= line_addr(req_tag, idx);
                end
                S_REFILL: if (mem.mem_ack_i) begin
                    state_q <= S_SETTLE;
                    en_q    <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
